// File: rtl/bcd_digit_feeder_pkg.sv
// Shared display definitions for the binary-to-BCD digit feeder.
// Digit geometry, saturation ceiling and the converter state encoding.
package bcd_digit_feeder_pkg;

   localparam int DIGITS    = 4;
   localparam int BCD_W     = 4;
   localparam int SCRATCH_W = DIGITS * BCD_W;
   localparam int SAT_VAL   = 9999;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_digit_feeder_add3.sv
// Double-dabble nibble correction: a digit of 5 or more gets +3 so the
// following left shift carries cleanly into the next decimal digit.
module bcd_add3
   import bcd_digit_feeder_pkg::*;
(
   input  logic [BCD_W-1:0] nibble,
   output logic [BCD_W-1:0] fixed
);

   assign fixed = (nibble >= BCD_W'(5)) ? nibble + BCD_W'(3) : nibble;

endmodule

// File: rtl/bcd_digit_feeder.sv
// Sequential binary-to-BCD converter feeding the 4-digit display driver.
// Digits, blink mask and overflow update atomically once per conversion.
module bcd_digit_feeder #(
   parameter int IN_W    = 14,
   parameter int SAT_VAL = bcd_digit_feeder_pkg::SAT_VAL
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IN_W-1:0] in_value,
   input  logic [3:0]      in_blink,
   output logic [3:0]      x1,
   output logic [3:0]      x2,
   output logic [3:0]      x3,
   output logic [3:0]      x4,
   output logic [3:0]      switch,
   output logic            overflow,
   output logic            done
);

   import bcd_digit_feeder_pkg::*;

   localparam int              CNT_W   = $clog2(IN_W);
   localparam logic [IN_W-1:0] SAT_LIM = IN_W'(SAT_VAL);

   state_t                        state;
   state_t                        next_state;
   logic                          accept;
   logic                          commit;
   logic [IN_W-1:0]               src;
   logic [SCRATCH_W-1:0]          scratch;
   logic [SCRATCH_W-1:0]          corrected;
   logic [SCRATCH_W+IN_W-1:0]     shifted;
   logic [CNT_W-1:0]              cnt;
   logic                          ovf_pend;
   logic [3:0]                    blink_pend;

   for (genvar i = 0; i < DIGITS; i++) begin : g_add3
      bcd_add3 u_add3 (
         .nibble (scratch[i*BCD_W +: BCD_W]),
         .fixed  (corrected[i*BCD_W +: BCD_W])
      );
   end

   // Corrected digits and the remaining source bits shift as one register.
   assign shifted  = {corrected, src} << 1;
   assign in_ready = (state == IDLE);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      commit     = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               accept     = 1'b1;
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == CNT_W'(IN_W - 1)) next_state = COMMIT;
         end
         COMMIT: begin
            commit     = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Visible outputs only ever load in COMMIT, so the display never sees a
   // half-converted value.
   always_ff @(posedge clock) begin
      if (reset) begin
         src        <= '0;
         scratch    <= '0;
         cnt        <= '0;
         ovf_pend   <= 1'b0;
         blink_pend <= '0;
         x1         <= '0;
         x2         <= '0;
         x3         <= '0;
         x4         <= '0;
         switch     <= '0;
         overflow   <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= commit;
         if (accept) begin
            src        <= (in_value > SAT_LIM) ? SAT_LIM : in_value;
            ovf_pend   <= (in_value > SAT_LIM);
            blink_pend <= in_blink;
            scratch    <= '0;
            cnt        <= '0;
         end else if (state == SHIFT) begin
            {scratch, src} <= shifted;
            cnt            <= cnt + CNT_W'(1);
         end
         if (commit) begin
            x1       <= scratch[3:0];
            x2       <= scratch[7:4];
            x3       <= scratch[11:8];
            x4       <= scratch[15:12];
            switch   <= blink_pend;
            overflow <= ovf_pend;
         end
      end
   end

endmodule
